// File: rtl/carry_skip_adder_pipe.sv
// carry_skip_adder_pipe: pipelined carry-skip adder/subtractor with valid/ready handshakes
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready with a, b, cin, sub (0: a+b+cin, 1: a-b);
//        out_valid/out_ready with sum, cout (sub: 1 = no borrow), ovf (signed overflow), zero.
module carry_skip_adder_pipe #(
    parameter int WIDTH  = 32,
    parameter int BLOCK  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int SW = WIDTH / STAGES;
    localparam int L  = STAGES - 1;

    // One slice: chain of ripple blocks whose carry-out bypasses the block when all bits propagate.
    function automatic logic [SW:0] slice_add(input logic [SW-1:0] x, input logic [SW-1:0] y, input logic c);
        logic [SW-1:0] s;
        logic bc, rc;
        s  = '0;
        bc = c;
        for (int k = 0; k < SW / BLOCK; k++) begin
            rc = bc;
            for (int j = 0; j < BLOCK; j++) begin
                s[k*BLOCK+j] = x[k*BLOCK+j] ^ y[k*BLOCK+j] ^ rc;
                rc = (x[k*BLOCK+j] & y[k*BLOCK+j]) | (rc & (x[k*BLOCK+j] ^ y[k*BLOCK+j]));
            end
            bc = &(x[k*BLOCK +: BLOCK] ^ y[k*BLOCK +: BLOCK]) ? bc : rc;
        end
        return {bc, s};
    endfunction

    logic [WIDTH-1:0]  ra [STAGES];
    logic [WIDTH-1:0]  rb [STAGES];
    logic [WIDTH-1:0]  rs [STAGES];
    logic [STAGES-1:0] rv, rc;
    logic [WIDTH-1:0]  na [STAGES];
    logic [WIDTH-1:0]  nb [STAGES];
    logic [WIDTH-1:0]  ns [STAGES];
    logic [SW:0]       r  [STAGES];
    logic [STAGES-1:0] nv, ci, nc;

    assign in_ready  = !out_valid || out_ready;
    assign out_valid = rv[L];
    assign sum       = rs[L];
    assign cout      = rc[L];

    // Full-width operands and partial sums travel with each op; stage s fills in its own slice.
    always_comb begin
        na[0] = a;
        nb[0] = sub ? ~b : b;
        ns[0] = '0;
        nv[0] = in_valid;
        ci[0] = sub | cin;
        for (int s = 1; s < STAGES; s++) begin
            na[s] = ra[s-1];
            nb[s] = rb[s-1];
            ns[s] = rs[s-1];
            nv[s] = rv[s-1];
            ci[s] = rc[s-1];
        end
        for (int s = 0; s < STAGES; s++) begin
            r[s] = slice_add(na[s][s*SW +: SW], nb[s][s*SW +: SW], ci[s]);
            ns[s][s*SW +: SW] = r[s][SW-1:0];
            nc[s] = r[s][SW];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rv   <= '0;
            rc   <= '0;
            ra   <= '{default: '0};
            rb   <= '{default: '0};
            rs   <= '{default: '0};
            ovf  <= 1'b0;
            zero <= 1'b0;
        end else if (in_ready) begin
            rv   <= nv;
            rc   <= nc;
            ra   <= na;
            rb   <= nb;
            rs   <= ns;
            ovf  <= (na[L][WIDTH-1] == nb[L][WIDTH-1]) && (ns[L][WIDTH-1] != na[L][WIDTH-1]);
            zero <= ns[L] == '0;
        end
    end
endmodule

// File: tb/tb_carry_skip_adder_pipe.sv
// tb_carry_skip_adder_pipe: directed and streaming checks of carry_skip_adder_pipe against an arithmetic model
module tb_carry_skip_adder_pipe;
    logic        clk = 0, rst_n = 0, in_valid = 0, cin = 0, sub = 0, out_ready = 1;
    logic        in_ready, out_valid, cout, ovf, zero;
    logic [31:0] a = 0, b = 0, sum;
    int          n_chk = 0, n_fail = 0, n_pop = 0, start;
    logic [34:0] q[$];
    logic        held = 0;
    logic [34:0] held_v;
    logic        iv [20];

    carry_skip_adder_pipe #(.WIDTH(32), .BLOCK(4), .STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
    );

    always #5 clk = ~clk;

    // Returns {zero, ovf, cout, sum} from plain wide arithmetic.
    function automatic logic [34:0] model(input logic [31:0] x, input logic [31:0] y, input logic c, input logic s);
        logic [31:0] yy;
        logic [32:0] t;
        logic        o;
        yy = s ? ~y : y;
        t  = {1'b0, x} + {1'b0, yy} + 33'(s ? 1'b1 : c);
        o  = (x[31] == yy[31]) && (t[31] != x[31]);
        return {t[31:0] == 32'd0, o, t[32], t[31:0]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] x, input logic [31:0] y, input logic c, input logic s, input logic v);
        a = x; b = y; cin = c; sub = s; in_valid = v;
    endtask

    task automatic one(input logic [31:0] x, input logic [31:0] y, input logic c, input logic s,
                       input logic [31:0] es, input logic ec, input logic eo, input logic ez, input string nm);
        drive(x, y, c, s, 1'b1);
        step;
        in_valid = 0;
        chk({nm, "_early"}, 64'(out_valid), 64'(0));
        step;
        chk({nm, "_valid"}, 64'(out_valid), 64'(1));
        chk({nm, "_sum"}, 64'(sum), 64'(es));
        chk({nm, "_cout"}, 64'(cout), 64'(ec));
        chk({nm, "_ovf"}, 64'(ovf), 64'(eo));
        chk({nm, "_zero"}, 64'(zero), 64'(ez));
        step;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            held = 0;
        end else begin
            chk("in_ready_rule", 64'(in_ready), 64'(!out_valid || out_ready));
            if (held) chk("hold", 64'({out_valid, zero, ovf, cout, sum}), 64'({1'b1, held_v}));
            if (out_valid) begin
                if (q.size() == 0) chk("spurious_out", 64'(out_valid), 64'(0));
                else begin
                    chk("result", 64'({zero, ovf, cout, sum}), 64'(q[0]));
                    if (out_ready) begin
                        void'(q.pop_front());
                        n_pop++;
                    end
                end
            end
            held   = out_valid && !out_ready;
            held_v = {zero, ovf, cout, sum};
            if (in_valid && in_ready) q.push_back(model(a, b, cin, sub));
        end
    end

    initial begin
        chk("model_sub", 64'(model(32'd5, 32'd7, 1'b0, 1'b1)), 64'({1'b0, 1'b0, 1'b0, 32'hFFFF_FFFE}));
        chk("model_wrap", 64'(model(32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0)), 64'({1'b1, 1'b0, 1'b1, 32'd0}));
        chk("model_ovf", 64'(model(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0)), 64'({1'b0, 1'b1, 1'b0, 32'h8000_0000}));
        step;
        step;
        chk("rst_valid", 64'(out_valid), 64'(0));
        chk("rst_flags", 64'({sum, cout, ovf, zero}), 64'(0));
        chk("rst_ready", 64'(in_ready), 64'(1));
        rst_n = 1;

        one(32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1, "skip_chain");
        one(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, "signed_ovf");
        one(32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, "sub_borrow");
        one(32'd8, 32'd5, 1'b1, 1'b1, 32'd3, 1'b1, 1'b0, 1'b0, "sub_noborrow");
        one(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b1, "neg_ovf");

        start = n_pop;
        for (int i = 0; i < 100; i++) begin
            drive($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
            step;
            if (i == 0) chk("stream_lat0", 64'(out_valid), 64'(0));
            if (i == 1) chk("stream_first", 64'(out_valid), 64'(1));
        end
        in_valid = 0;
        step;
        step;
        chk("stream_count", 64'(n_pop - start), 64'(100));
        chk("stream_done", 64'(out_valid), 64'(0));

        out_ready = 0;
        drive(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0, 1'b1);
        step;
        drive(32'hF0F0_F0F0, 32'h0F0F_0F0F, 1'b1, 1'b0, 1'b1);
        step;
        drive(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 5; k++) begin
            step;
            chk("bp_in_ready", 64'(in_ready), 64'(0));
            chk("bp_valid", 64'(out_valid), 64'(1));
            chk("bp_sum", 64'(sum), 64'(32'h3333_3333));
        end
        out_ready = 1;
        step;
        in_valid = 0;
        chk("bp_drain1", 64'({zero, cout, sum}), 64'({1'b1, 1'b1, 32'd0}));
        step;
        chk("bp_drain2", 64'({cout, sum}), 64'({1'b0, 32'h7777_7788}));
        step;
        chk("bp_empty", 64'(out_valid), 64'(0));

        drive(32'd1, 32'd2, 1'b0, 1'b0, 1'b1);
        step;
        drive(32'd3, 32'd4, 1'b0, 1'b0, 1'b1);
        step;
        rst_n = 0;
        in_valid = 0;
        step;
        chk("mrst_valid", 64'(out_valid), 64'(0));
        chk("mrst_outs", 64'({sum, cout, ovf, zero}), 64'(0));
        chk("mrst_ready", 64'(in_ready), 64'(1));
        rst_n = 1;
        drive(32'h10, 32'h20, 1'b0, 1'b0, 1'b1);
        step;
        in_valid = 0;
        chk("mrst_lat", 64'(out_valid), 64'(0));
        step;
        chk("mrst_new", 64'({out_valid, sum}), 64'({1'b1, 32'h30}));
        step;
        step;
        chk("mrst_nostale", 64'(out_valid), 64'(0));

        for (int i = 0; i < 20; i++) begin
            iv[i] = (i % 2) == 0;
            drive(32'(i * 32'h0101_0101), 32'(i * 5 + 1), 1'(i % 3 == 0), 1'(i % 4 == 1), iv[i]);
            step;
            chk("bubble_valid", 64'(out_valid), 64'(i > 0 ? iv[i-1] : 1'b0));
        end
        in_valid = 0;
        step;
        step;
        chk("drain_empty", 64'(q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
